// File: rtl/mig_app_pkg.sv
// Shared MIG app-port command encodings and requester FSM states.
package mig_app_pkg;
   localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
   localparam logic [2:0] MIG_CMD_READ  = 3'b001;

   typedef enum logic [1:0] {CALIB, IDLE, WR, RD} state_t;
endpackage

// File: rtl/mig_rd_resp_fifo.sv
// First-word-fall-through read-response buffer; head is visible the cycle after the push edge.
// A push is refused only when full with no same-cycle pop, which raises a one-cycle overflow strobe.
module mig_rd_resp_fifo #(
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign overflow = push & ~do_push;
   assign head     = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/mig_app_requester.sv
// MIG 7-series app-port requester: request accepted at edge N drives registered app_en/app_wdf_wren from N+1.
// Reads are credit-limited to the response FIFO depth because MIG read data cannot be stalled.
module mig_app_requester
   import mig_app_pkg::*;
#(
   parameter int ADDR_WIDTH   = 30,
   parameter int DATA_WIDTH   = 512,
   parameter int MASK_WIDTH   = 64,
   parameter int RD_BUF_DEPTH = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  init_calib_complete,
   input  logic                  req_valid,
   output logic                  req_rdy,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [MASK_WIDTH-1:0] req_mask,
   output logic                  rsp_valid,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [ADDR_WIDTH-1:0] app_addr,
   output logic [2:0]            app_cmd,
   output logic                  app_en,
   input  logic                  app_rdy,
   output logic [DATA_WIDTH-1:0] app_wdf_data,
   output logic [MASK_WIDTH-1:0] app_wdf_mask,
   output logic                  app_wdf_wren,
   output logic                  app_wdf_end,
   input  logic                  app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0] app_rd_data,
   input  logic                  app_rd_data_valid,
   output logic                  err_overflow
);
   localparam int CW = $clog2(RD_BUF_DEPTH) + 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(RD_BUF_DEPTH);
   localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] credit;
   logic          cmd_done;
   logic          dat_done;
   logic          take;
   logic          take_rd;
   logic          cmd_hs;
   logic          wdf_hs;
   logic          wr_fin;
   logic          rsp_pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_ovf;

   assign req_rdy     = (state == IDLE) & init_calib_complete & (req_write | (credit != '0));
   assign take        = req_valid & req_rdy;
   assign take_rd     = take & ~req_write;
   assign cmd_hs      = app_en & app_rdy;
   assign wdf_hs      = app_wdf_wren & app_wdf_rdy;
   // A write retires on whichever handshake lands last, including this cycle's.
   assign wr_fin      = (cmd_done | cmd_hs) & (dat_done | wdf_hs);
   assign rsp_valid   = ~fifo_empty;
   assign rsp_pop     = rsp_valid & rsp_rdy;
   assign app_wdf_end = app_wdf_wren;

   always_comb begin
      state_nxt = state;
      case (state)
         CALIB: if (init_calib_complete) state_nxt = IDLE;
         IDLE: begin
            if (!init_calib_complete) state_nxt = CALIB;
            else if (take)            state_nxt = req_write ? WR : RD;
         end
         WR:      if (wr_fin) state_nxt = IDLE;
         RD:      if (cmd_hs) state_nxt = IDLE;
         default: state_nxt = CALIB;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= CALIB;
      else        state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         app_en       <= 1'b0;
         app_cmd      <= '0;
         app_addr     <= '0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         app_wdf_wren <= 1'b0;
         cmd_done     <= 1'b0;
         dat_done     <= 1'b0;
         credit       <= CREDIT_MAX;
         err_overflow <= 1'b0;
      end else begin
         if (take) begin
            app_en       <= 1'b1;
            app_cmd      <= req_write ? MIG_CMD_WRITE : MIG_CMD_READ;
            app_addr     <= req_addr;
            app_wdf_wren <= req_write;
            cmd_done     <= 1'b0;
            dat_done     <= 1'b0;
            if (req_write) begin
               app_wdf_data <= req_wdata;
               app_wdf_mask <= req_mask;
            end
         end else begin
            if (cmd_hs) begin
               app_en   <= 1'b0;
               cmd_done <= 1'b1;
            end
            if (wdf_hs) begin
               app_wdf_wren <= 1'b0;
               dat_done     <= 1'b1;
            end
         end
         case ({take_rd, rsp_pop})
            2'b10:   credit <= credit - CREDIT_ONE;
            2'b01:   credit <= credit + CREDIT_ONE;
            default: ;
         endcase
         if (fifo_ovf) err_overflow <= 1'b1;
      end
   end

   mig_rd_resp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RD_BUF_DEPTH)
   ) u_rd_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (app_rd_data_valid),
      .push_data (app_rd_data),
      .pop       (rsp_pop),
      .head      (rsp_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .overflow  (fifo_ovf)
   );
endmodule

// File: tb/tb_mig_app_requester.sv
// Bench for mig_app_requester: expectations queued at request acceptance, checked by a monitor
// on app_* and rsp handshakes against a simple MIG memory model.
module tb_mig_app_requester;
   import mig_app_pkg::*;

   localparam int AW = 30;
   localparam int DW = 512;
   localparam int MW = 64;
   localparam int DEPTH = 16;

   typedef logic [DW-1:0] data_t;
   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      data_t         data;
      logic [MW-1:0] mask;
   } req_t;
   typedef struct {
      int    due;
      data_t data;
   } ret_t;

   logic          CLK;
   logic          RST_N;
   logic          init_calib_complete;
   logic          req_valid;
   logic          req_rdy;
   logic          req_write;
   logic [AW-1:0] req_addr;
   data_t         req_wdata;
   logic [MW-1:0] req_mask;
   logic          rsp_valid;
   logic          rsp_rdy;
   data_t         rsp_data;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy;
   data_t         app_wdf_data;
   logic [MW-1:0] app_wdf_mask;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic          app_wdf_rdy;
   data_t         app_rd_data;
   logic          app_rd_data_valid;
   logic          err_overflow;

   mig_app_requester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RD_BUF_DEPTH(DEPTH)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .init_calib_complete(init_calib_complete),
      .req_valid(req_valid), .req_rdy(req_rdy), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
      .rsp_valid(rsp_valid), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .err_overflow(err_overflow)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int n_rd_cmd = 0;
   int n_rd_acc = 0;
   int n_pop = 0;
   int acc_edge = 0;
   int last_cmd_edge = 0;
   int last_wdf_edge = 0;
   int inj_req = 0;
   int inj_done = 0;
   data_t inj_data;
   bit rnd_rdy = 0;
   bit rnd_rsp = 0;
   bit f_app_rdy = 1;
   bit f_wdf_rdy = 1;
   bit f_rsp_rdy = 0;
   bit sends_done = 0;

   req_t          exp_cmd_q[$];
   req_t          exp_wdf_q[$];
   data_t         exp_rsp_q[$];
   ret_t          ret_q[$];
   logic [AW-1:0] mig_wa_q[$];
   req_t          mig_wd_q[$];
   data_t         ref_mem[int];
   data_t         mig_mem[int];
   req_t          mon_e;
   req_t          mon_w;
   ret_t          mon_r;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic data_t init_word(logic [AW-1:0] a);
      return {16{2'b10, a}};
   endfunction

   // Mask bit 1 protects the byte; unmasked bytes take the new data.
   function automatic data_t merge(data_t old, data_t nw, logic [MW-1:0] m);
      data_t r = old;
      for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   function automatic data_t rnd_data();
      data_t r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic data_t ref_rd(logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
   endfunction

   function automatic data_t mig_rd(logic [AW-1:0] a);
      return mig_mem.exists(int'(a)) ? mig_mem[int'(a)] : init_word(a);
   endfunction

   task automatic chk(input string nm, input data_t act, input data_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the acceptance edge.
   task automatic send(input logic wr, input logic [AW-1:0] a, input data_t d, input logic [MW-1:0] m);
      req_t r;
      int   waited;
      r.wr = wr; r.addr = a; r.data = d; r.mask = m;
      waited = 0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_mask = m;
      @(negedge CLK);
      while (!req_rdy && waited < 500) begin
         @(negedge CLK);
         waited++;
      end
      if (!req_rdy) begin
         tests++; fails++;
         $display("FAIL send_timeout: req_rdy stayed %0b, required 1", req_rdy);
         @(posedge CLK); #1;
         req_valid = 1'b0;
         return;
      end
      acc_edge = cyc + 1;
      exp_cmd_q.push_back(r);
      if (wr) begin
         exp_wdf_q.push_back(r);
         ref_mem[int'(a)] = merge(ref_rd(a), d, m);
      end else begin
         exp_rsp_q.push_back(ref_rd(a));
         n_rd_acc++;
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while ((exp_cmd_q.size() + exp_wdf_q.size() + exp_rsp_q.size()) != 0 && k < 2000) begin
         @(posedge CLK);
         k++;
      end
      @(posedge CLK); #1;
      chk(nm, data_t'(exp_cmd_q.size() + exp_wdf_q.size() + exp_rsp_q.size()), data_t'(0));
   endtask

   // MIG-side model: ready strobes and in-order read returns after a random latency.
   initial begin : mig_drv
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; rsp_rdy = 1'b0;
      app_rd_data_valid = 1'b0; app_rd_data = '0;
      forever begin
         @(posedge CLK); #2;
         app_rdy     = rnd_rdy ? ($urandom_range(0, 3) != 0) : f_app_rdy;
         app_wdf_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : f_wdf_rdy;
         rsp_rdy     = rnd_rsp ? ($urandom_range(0, 1) != 0) : f_rsp_rdy;
         app_rd_data_valid = 1'b0;
         if (inj_req != inj_done) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = inj_data;
            inj_done++;
         end else if (ret_q.size() != 0 && cyc >= ret_q[0].due) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = ret_q[0].data;
            void'(ret_q.pop_front());
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            if (app_en && app_rdy) begin
               if (exp_cmd_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL cmd_unexpected: got addr %0h, required no command", app_addr);
               end else begin
                  mon_e = exp_cmd_q.pop_front();
                  chk("app_cmd", data_t'(app_cmd), data_t'(mon_e.wr ? MIG_CMD_WRITE : MIG_CMD_READ));
                  chk("app_addr", data_t'(app_addr), data_t'(mon_e.addr));
                  last_cmd_edge = cyc + 1;
                  if (mon_e.wr) mig_wa_q.push_back(app_addr);
                  else begin
                     mon_r.due  = cyc + int'($urandom_range(2, 8));
                     mon_r.data = mig_rd(app_addr);
                     ret_q.push_back(mon_r);
                     n_rd_cmd++;
                  end
               end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
               if (exp_wdf_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL wdf_unexpected: got data %0h, required no write data", app_wdf_data);
               end else begin
                  mon_e = exp_wdf_q.pop_front();
                  chk("wdf_data", app_wdf_data, mon_e.data);
                  chk("wdf_mask", data_t'(app_wdf_mask), data_t'(mon_e.mask));
                  chk("wdf_end", data_t'(app_wdf_end), data_t'(1'b1));
                  last_wdf_edge = cyc + 1;
                  mig_wd_q.push_back(mon_e);
               end
            end
            while (mig_wa_q.size() != 0 && mig_wd_q.size() != 0) begin
               mon_w = mig_wd_q.pop_front();
               mig_mem[int'(mig_wa_q[0])] = merge(mig_rd(mig_wa_q[0]), mon_w.data, mon_w.mask);
               void'(mig_wa_q.pop_front());
            end
            if (rsp_valid && rsp_rdy) begin
               n_pop++;
               if (exp_rsp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL rsp_unexpected: got %0h, required no response", rsp_data);
               end else chk("rsp_data", rsp_data, exp_rsp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      fails++;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : stim
      int   bad;
      int   n;
      int   base;
      data_t wd;
      logic [MW-1:0] wm;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
      RST_N = 1'b0; init_calib_complete = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      chk("rst_outputs", data_t'({app_en, app_wdf_wren, app_wdf_end, rsp_valid, err_overflow, req_rdy}), data_t'(0));
      chk("rst_credit", data_t'(dut.credit), data_t'(DEPTH));
      @(posedge CLK); #1;
      RST_N = 1'b1;

      // Calibration gate: no acceptance and no command while calibration is pending.
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(5);
      bad = 0;
      repeat (100) begin
         @(negedge CLK);
         if (req_rdy || app_en) bad++;
      end
      chk("calib_gate", data_t'(bad), data_t'(0));
      @(posedge CLK); #1;
      req_valid = 1'b0; req_write = 1'b1; init_calib_complete = 1'b1;
      @(negedge CLK);
      chk("calib_rdy_same_cycle", data_t'(req_rdy), data_t'(0));
      @(negedge CLK);
      chk("calib_rdy_next_cycle", data_t'(req_rdy), data_t'(1));
      @(posedge CLK); #1;

      // Write with data accepted first and the command held off for three cycles.
      f_app_rdy = 1'b0; f_wdf_rdy = 1'b1;
      wd = rnd_data(); wm = {$urandom, $urandom};
      send(1'b1, AW'(30'h2A), wd, wm);
      n = acc_edge;
      @(negedge CLK);
      chk("wr_issue", data_t'({app_en, app_wdf_wren, app_wdf_end}), data_t'(3'b111));
      @(negedge CLK);
      chk("wr_data_first", data_t'({app_en, app_wdf_wren}), data_t'(2'b10));
      @(posedge CLK); @(posedge CLK); #1;
      f_app_rdy = 1'b1;
      @(negedge CLK); @(negedge CLK);
      chk("wr_wdf_edge", data_t'(last_wdf_edge - n), data_t'(1));
      chk("wr_cmd_edge", data_t'(last_cmd_edge - n), data_t'(4));
      chk("wr_back_idle", data_t'({app_en, app_wdf_wren, req_rdy}), data_t'(3'b001));
      @(posedge CLK); #1;

      // Random mixed traffic with random MIG and consumer readiness.
      rnd_rdy = 1'b1; rnd_rsp = 1'b1;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            @(posedge CLK); #1;
         end
         send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rnd_data(), {$urandom, $urandom});
      end
      drain("drain_random");
      chk("credit_after_random", data_t'(dut.credit), data_t'(DEPTH - n_rd_acc + n_pop));

      // Read stream against a stalled consumer: credits cap issue at the FIFO depth.
      rnd_rdy = 1'b0; rnd_rsp = 1'b0; f_app_rdy = 1'b1; f_wdf_rdy = 1'b1; f_rsp_rdy = 1'b0;
      base = n_rd_cmd; sends_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) send(1'b0, AW'($urandom_range(0, 15)), '0, '0);
            sends_done = 1'b1;
         end
      join_none
      repeat (60) @(posedge CLK);
      @(negedge CLK);
      chk("rd_issue_capped", data_t'(n_rd_cmd - base), data_t'(DEPTH));
      chk("rd_req_stalled", data_t'(req_rdy), data_t'(0));
      chk("rd_no_overflow", data_t'(err_overflow), data_t'(0));

      // Extra beat at full must be dropped and flagged.
      @(posedge CLK); #1;
      inj_data = rnd_data();
      inj_req++;
      @(negedge CLK); @(negedge CLK);
      chk("ovf_set", data_t'(err_overflow), data_t'(1));
      repeat (5) @(negedge CLK);
      chk("ovf_sticky", data_t'(err_overflow), data_t'(1));

      @(posedge CLK); #1;
      f_rsp_rdy = 1'b1;
      @(posedge CLK); #1;
      f_rsp_rdy = 1'b0;
      repeat (30) @(posedge CLK);
      @(negedge CLK);
      chk("rd_one_more_after_pop", data_t'(n_rd_cmd - base), data_t'(DEPTH + 1));
      @(posedge CLK); #1;
      f_rsp_rdy = 1'b1;
      for (int k = 0; k < 2000 && !sends_done; k++) @(posedge CLK);
      #1;
      chk("rd_stream_sent", data_t'(sends_done), data_t'(1));
      drain("drain_rd_stream");

      // Read accepted on the same edge as a pop with one credit left.
      f_rsp_rdy = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) send(1'b0, AW'($urandom_range(0, 15)), '0, '0);
      repeat (20) @(posedge CLK);
      @(negedge CLK);
      chk("sim_credit_before", data_t'(dut.credit), data_t'(1));
      @(posedge CLK); #1;
      f_rsp_rdy = 1'b1;
      send(1'b0, AW'($urandom_range(0, 15)), '0, '0);
      f_rsp_rdy = 1'b0;
      @(negedge CLK);
      chk("sim_credit_after", data_t'(dut.credit), data_t'(1));
      @(posedge CLK); #1;
      f_rsp_rdy = 1'b1;
      drain("drain_simultaneous");

      // Reset in the middle of a write, with a response buffered and overflow still flagged.
      f_rsp_rdy = 1'b0;
      send(1'b0, AW'(3), '0, '0);
      repeat (15) @(posedge CLK);
      @(negedge CLK);
      chk("pre_rst_rsp_valid", data_t'({rsp_valid, err_overflow}), data_t'(2'b11));
      @(posedge CLK); #1;
      f_app_rdy = 1'b0; f_wdf_rdy = 1'b0;
      send(1'b1, AW'(9), rnd_data(), {$urandom, $urandom});
      @(negedge CLK);
      chk("pre_rst_app_en", data_t'({app_en, app_wdf_wren}), data_t'(2'b11));
      @(posedge CLK); #1;
      RST_N = 1'b0;
      exp_cmd_q.delete(); exp_wdf_q.delete(); exp_rsp_q.delete();
      ret_q.delete(); mig_wa_q.delete(); mig_wd_q.delete();
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_mid_ctrl", data_t'({app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr, app_wdf_mask}), data_t'(0));
      chk("rst_mid_wdata", app_wdf_data, data_t'(0));
      chk("rst_mid_credit", data_t'(dut.credit), data_t'(DEPTH));
      chk("rst_mid_status", data_t'({rsp_valid, err_overflow, req_rdy}), data_t'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
